// File: rtl/lcd_pkg.sv
// Shared constants, bus bundle, opcode decode table and FSM states
// for the HD44780-compatible LCD responder.
package lcd_pkg;

    localparam int ADDR_W      = 7;
    localparam int DDRAM_DEPTH = 128;

    localparam logic [7:0]        FILL_CHAR = 8'h20;
    localparam logic [ADDR_W-1:0] ADDR_MAX  = 7'h7F;

    // Highest set bit selects the opcode, so these pairs never overlap.
    localparam logic [7:0] OP_CLR_MASK   = 8'hFF;
    localparam logic [7:0] OP_CLR_VAL    = 8'h01;
    localparam logic [7:0] OP_HOME_MASK  = 8'hFE;
    localparam logic [7:0] OP_HOME_VAL   = 8'h02;
    localparam logic [7:0] OP_ENTRY_MASK = 8'hFC;
    localparam logic [7:0] OP_ENTRY_VAL  = 8'h04;
    localparam logic [7:0] OP_DISP_MASK  = 8'hF8;
    localparam logic [7:0] OP_DISP_VAL   = 8'h08;
    localparam logic [7:0] OP_SHIFT_MASK = 8'hF0;
    localparam logic [7:0] OP_SHIFT_VAL  = 8'h10;
    localparam logic [7:0] OP_FUNC_MASK  = 8'hE0;
    localparam logic [7:0] OP_FUNC_VAL   = 8'h20;
    localparam logic [7:0] OP_CGRAM_MASK = 8'hC0;
    localparam logic [7:0] OP_CGRAM_VAL  = 8'h40;
    localparam logic [7:0] OP_DDRAM_MASK = 8'h80;
    localparam logic [7:0] OP_DDRAM_VAL  = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CLEAR
    } lcd_state_e;

    typedef struct packed {
        logic       en;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } lcd_bus_t;

    function automatic logic [ADDR_W-1:0] ac_step(
        input logic [ADDR_W-1:0] ac,
        input logic              inc
    );
        return inc ? ac + 7'd1 : ac - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 128x8 display RAM: port A async-read/sync-write for bus and fill,
// port B registered read-first read for the character port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [7:0]        i_a_wdata,
    output logic [7:0]        o_a_rdata,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic [7:0]        o_b_rdata
);

    logic [7:0] r_mem [0:DDRAM_DEPTH-1];
    logic [7:0] r_b_rdata;

    always_ff @(posedge i_clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_b_rdata <= '0;
        end else begin
            r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_mem[i_a_addr];
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible LCD bus responder: DDRAM, address counter, busy flag.
// Define LCD_SYNC_EN to add two-FF synchronizers on asynchronous bus pins.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS      = 8,
    parameter int unsigned BUSY_CYCLES       = 2000,
    parameter int unsigned CLEAR_BUSY_CYCLES = 82000
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic [PAYLOAD_BITS-1:0] LCD_DATA_I,
    input  logic                    LCD_RS_I,
    input  logic                    LCD_RW_I,
    input  logic                    LCD_EN_I,
    output logic [PAYLOAD_BITS-1:0] LCD_DATA_O,
    output logic                    LCD_DATA_OE_O,
    input  logic [ADDR_W-1:0]       CHAR_ADDR_I,
    output logic [7:0]              CHAR_DATA_O,
    output logic                    DISP_ON_O,
    output logic                    BUSY_O,
    output logic                    CMD_ERR_O
);

    localparam int unsigned CLR_TAIL =
        (CLEAR_BUSY_CYCLES > DDRAM_DEPTH) ? CLEAR_BUSY_CYCLES - DDRAM_DEPTH : 0;

    lcd_bus_t w_bus_raw;
    lcd_bus_t r_bus_q;

    assign w_bus_raw = '{en: LCD_EN_I, rs: LCD_RS_I,
                         rw: LCD_RW_I, data: LCD_DATA_I};

`ifdef LCD_SYNC_EN
    lcd_bus_t r_sync1;
    lcd_bus_t r_sync2;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_bus_q <= '0;
        end else begin
            r_sync1 <= w_bus_raw;
            r_sync2 <= r_sync1;
            r_bus_q <= r_sync2;
        end
    end
`else
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_bus_q <= '0;
        end else begin
            r_bus_q <= w_bus_raw;
        end
    end
`endif

    lcd_state_e        r_state, w_state_nx;
    logic [31:0]       r_cnt, w_cnt_nx;
    logic [ADDR_W-1:0] r_fill, w_fill_nx;
    logic [ADDR_W-1:0] r_ac, w_ac_nx;
    logic              r_id, w_id_nx;
    logic              r_disp, w_disp_nx;
    logic              r_long, w_long_nx;
    logic              r_err, w_err_nx;
    logic              r_en_d;
    logic              r_oe;
    logic [7:0]        r_lcd_do;
    logic              w_we;
    logic [7:0]        w_wdata;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_a_rdata;
    logic              w_fall;
    logic              w_busy;
    logic [7:0]        w_d;

    assign w_d    = r_bus_q.data;
    assign w_fall = r_en_d & ~r_bus_q.en;
    assign w_busy = (r_state != ST_IDLE);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_fill_nx  = r_fill;
        w_ac_nx    = r_ac;
        w_id_nx    = r_id;
        w_disp_nx  = r_disp;
        w_long_nx  = r_long;
        w_err_nx   = 1'b0;
        w_we       = 1'b0;
        w_wdata    = w_d;
        w_addr     = r_ac;

        unique case (r_state)
            ST_CLEAR: begin
                w_we      = 1'b1;
                w_wdata   = FILL_CHAR;
                w_addr    = r_fill;
                w_fill_nx = r_fill + 7'd1;
                if (r_fill == ADDR_MAX) begin
                    if (r_long && CLR_TAIL != 0) begin
                        w_state_nx = ST_EXEC;
                        w_cnt_nx   = 32'(CLR_TAIL - 1);
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            ST_EXEC: begin
                if (r_cnt == 32'd0) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 32'd1;
                end
            end
            default: ;
        endcase

        // Writes commit only from IDLE; reads never touch BF.
        if (w_fall) begin
            if (r_bus_q.rw) begin
                if (r_bus_q.rs) begin
                    w_ac_nx = ac_step(r_ac, r_id);
                end
            end else if (w_busy) begin
                w_err_nx = 1'b1;
            end else if (r_bus_q.rs) begin
                w_we       = 1'b1;
                w_ac_nx    = ac_step(r_ac, r_id);
                w_state_nx = ST_EXEC;
                w_cnt_nx   = 32'(BUSY_CYCLES - 1);
            end else begin
                w_state_nx = ST_EXEC;
                w_cnt_nx   = 32'(BUSY_CYCLES - 1);
                unique case (1'b1)
                    ((w_d & OP_DDRAM_MASK) == OP_DDRAM_VAL):
                        w_ac_nx = w_d[ADDR_W-1:0];
                    ((w_d & OP_CGRAM_MASK) == OP_CGRAM_VAL): ;
                    ((w_d & OP_FUNC_MASK) == OP_FUNC_VAL): ;
                    ((w_d & OP_SHIFT_MASK) == OP_SHIFT_VAL):
                        if (!w_d[3]) w_ac_nx = ac_step(r_ac, w_d[2]);
                    ((w_d & OP_DISP_MASK) == OP_DISP_VAL):
                        w_disp_nx = w_d[2];
                    ((w_d & OP_ENTRY_MASK) == OP_ENTRY_VAL):
                        w_id_nx = w_d[1];
                    ((w_d & OP_HOME_MASK) == OP_HOME_VAL): begin
                        w_ac_nx  = '0;
                        w_cnt_nx = 32'(CLEAR_BUSY_CYCLES - 1);
                    end
                    ((w_d & OP_CLR_MASK) == OP_CLR_VAL): begin
                        w_state_nx = ST_CLEAR;
                        w_fill_nx  = '0;
                        w_ac_nx    = '0;
                        w_id_nx    = 1'b1;
                        w_long_nx  = 1'b1;
                    end
                    default:
                        w_state_nx = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state  <= ST_CLEAR;
            r_cnt    <= '0;
            r_fill   <= '0;
            r_ac     <= '0;
            r_id     <= 1'b1;
            r_disp   <= 1'b0;
            r_long   <= 1'b0;
            r_err    <= 1'b0;
            r_en_d   <= 1'b0;
            r_oe     <= 1'b0;
            r_lcd_do <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_fill  <= w_fill_nx;
            r_ac    <= w_ac_nx;
            r_id    <= w_id_nx;
            r_disp  <= w_disp_nx;
            r_long  <= w_long_nx;
            r_err   <= w_err_nx;
            r_en_d  <= r_bus_q.en;
            r_oe    <= r_bus_q.en & r_bus_q.rw;
            if (r_bus_q.en && r_bus_q.rw) begin
                r_lcd_do <= r_bus_q.rs ? w_a_rdata : {w_busy, r_ac};
            end
        end
    end

    lcd_ddram u_ddram (
        .i_clk     (CLK_I),
        .i_rst     (RST_I),
        .i_a_we    (w_we & ~RST_I),
        .i_a_addr  (w_addr),
        .i_a_wdata (w_wdata),
        .o_a_rdata (w_a_rdata),
        .i_b_addr  (CHAR_ADDR_I),
        .o_b_rdata (CHAR_DATA_O)
    );

    assign LCD_DATA_O    = r_lcd_do;
    assign LCD_DATA_OE_O = r_oe;
    assign DISP_ON_O     = r_disp;
    assign BUSY_O        = w_busy;
    assign CMD_ERR_O     = r_err;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder with a scoreboard queue
// of expected read/char values and immediate-assertion checks.
module tb_lcd_hd44780_responder;

    localparam int BUSY = 20;
    localparam int CLRB = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] lcd_di = '0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_en = 1'b0;
    logic [7:0] lcd_do;
    logic       lcd_oe;
    logic [6:0] char_addr = '0;
    logic [7:0] char_data;
    logic       disp_on;
    logic       busy;
    logic       cmd_err;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    lcd_hd44780_responder #(
        .PAYLOAD_BITS      (8),
        .BUSY_CYCLES       (BUSY),
        .CLEAR_BUSY_CYCLES (CLRB)
    ) dut (
        .CLK_I         (clk),
        .RST_I         (rst),
        .LCD_DATA_I    (lcd_di),
        .LCD_RS_I      (lcd_rs),
        .LCD_RW_I      (lcd_rw),
        .LCD_EN_I      (lcd_en),
        .LCD_DATA_O    (lcd_do),
        .LCD_DATA_OE_O (lcd_oe),
        .CHAR_ADDR_I   (char_addr),
        .CHAR_DATA_O   (char_data),
        .DISP_ON_O     (disp_on),
        .BUSY_O        (busy),
        .CMD_ERR_O     (cmd_err)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [7:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, {24'd0, obs}, {24'd0, e.val});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick(1);
            n++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic lcd_write(input logic rs, input logic [7:0] d,
                             output logic err);
        lcd_rs = rs;
        lcd_rw = 1'b0;
        lcd_di = d;
        lcd_en = 1'b1;
        tick(2);
        lcd_en = 1'b0;
        tick(2);
        err = cmd_err;
    endtask

    task automatic lcd_read(input string tag, input logic rs,
                            input logic [7:0] exp);
        logic [7:0] d;
        logic       oe_hi;
        sb_push(tag, exp);
        lcd_rs = rs;
        lcd_rw = 1'b1;
        lcd_en = 1'b1;
        tick(2);
        d     = lcd_do;
        oe_hi = lcd_oe;
        lcd_en = 1'b0;
        tick(2);
        sb_pop_check(d);
        chk({tag, "_oe_hi"}, {31'd0, oe_hi}, 32'd1);
        chk({tag, "_oe_lo"}, {31'd0, lcd_oe}, 32'd0);
        lcd_rw = 1'b0;
    endtask

    task automatic char_read(input string tag, input logic [6:0] a,
                             input logic [7:0] exp);
        sb_push(tag, exp);
        char_addr = a;
        tick(1);
        sb_pop_check(char_data);
    endtask

    task automatic cmd(input logic rs, input logic [7:0] d);
        logic err;
        wait_idle();
        lcd_write(rs, d, err);
        chk("write_no_err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        logic [7:0] seq [5];
        logic       err;
        int         n;

        seq = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};

        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_disp", {31'd0, disp_on}, 32'd0);
        chk("rst_err", {31'd0, cmd_err}, 32'd0);
        chk("rst_oe", {31'd0, lcd_oe}, 32'd0);
        chk("rst_do", {24'd0, lcd_do}, 32'd0);
        chk("rst_char", {24'd0, char_data}, 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            tick(1);
        end
        chk("rst_busy_len", n, 32'd128);
        for (int a = 0; a < 128; a++) begin
            char_read("fill", 7'(a), 8'h20);
        end

        foreach (seq[i]) cmd(1'b0, seq[i]);
        cmd(1'b1, 8'h48);
        cmd(1'b1, 8'h69);
        wait_idle();
        chk("disp_on", {31'd0, disp_on}, 32'd1);
        char_read("ddram0", 7'd0, 8'h48);
        char_read("ddram1", 7'd1, 8'h69);
        lcd_read("status_02", 1'b0, 8'h02);

        cmd(1'b0, 8'h06);
        lcd_write(1'b1, 8'h41, err);
        chk("busy_err_pulse", {31'd0, err}, 32'd1);
        tick(1);
        chk("busy_err_single", {31'd0, cmd_err}, 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            tick(1);
        end
        chk("busy_not_restarted", n, 32'(BUSY - 5));
        char_read("busy_ddram2", 7'd2, 8'h20);
        char_read("busy_ddram0", 7'd0, 8'h48);
        lcd_read("busy_ac_same", 1'b0, 8'h02);

        cmd(1'b0, 8'h04);
        cmd(1'b0, 8'h80);
        cmd(1'b1, 8'h41);
        wait_idle();
        char_read("dec_ddram0", 7'd0, 8'h41);
        lcd_read("status_7f", 1'b0, 8'h7F);

        cmd(1'b0, 8'h06);
        cmd(1'b0, 8'hFF);
        cmd(1'b1, 8'h5A);
        wait_idle();
        char_read("ddram7f", 7'h7F, 8'h5A);
        lcd_read("status_wrap", 1'b0, 8'h00);

        cmd(1'b0, 8'h08);
        wait_idle();
        chk("disp_off", {31'd0, disp_on}, 32'd0);

        cmd(1'b0, 8'h01);
        lcd_read("status_clr", 1'b0, 8'h80);
        wait_idle();
        lcd_read("status_after_clr", 1'b0, 8'h00);
        char_read("clr_ddram0", 7'd0, 8'h20);
        char_read("clr_ddram7f", 7'h7F, 8'h20);

        cmd(1'b0, 8'h14);
        wait_idle();
        lcd_read("status_shift", 1'b0, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
